// File: rtl/bira_pkg.sv
// Shared constants, FSM encoding and spare-configuration lookup for the
// built-in redundancy analysis fault collector.
package bira_pkg;

    localparam int ROW_W = 10;
    localparam int COL_W = 10;
    localparam int DEPTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE,
        TERM
    } state_t;

    // Number of distinct faults the selected spare configuration can still repair.
    function automatic logic [3:0] max_fault(input logic [1:0] spare);
        case (spare)
            2'b00:   max_fault = 4'd4;
            2'b01:   max_fault = 4'd6;
            default: max_fault = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/fault_cam.sv
// Fault-list storage: DEPTH row/column entries with a parallel match against
// an incoming address plus one indexed write port and one indexed read port.
module fault_cam #(
    parameter int ROW_W = bira_pkg::ROW_W,
    parameter int COL_W = bira_pkg::COL_W,
    parameter int DEPTH = bira_pkg::DEPTH,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [ROW_W-1:0] wr_row_i,
    input  logic [COL_W-1:0] wr_col_i,
    input  logic [ROW_W-1:0] cmp_row_i,
    input  logic [COL_W-1:0] cmp_col_i,
    output logic             hit_o,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [ROW_W-1:0] rd_row_o,
    output logic [COL_W-1:0] rd_col_o
);
    import bira_pkg::*;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] match;
    logic [ROW_W-1:0] row_q [DEPTH];
    logic [COL_W-1:0] col_q [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = vld_q[i] && (row_q[i] == cmp_row_i) && (col_q[i] == cmp_col_i);
        end
    end

    assign hit_o = |match;

    always_comb begin
        vld_d = vld_q;
        if (clr_i) begin
            vld_d = '0;
        end else if (wr_en_i) begin
            vld_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Entry payload needs no reset: only entries with a set valid bit are ever observed.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            row_q[wr_idx_i] <= wr_row_i;
            col_q[wr_idx_i] <= wr_col_i;
        end
    end

    assign rd_row_o = row_q[rd_idx_i];
    assign rd_col_o = col_q[rd_idx_i];

endmodule

// File: rtl/fault_collector.sv
// Collects distinct BIST fault addresses during a test session, flags early
// termination when the spare budget is exceeded, then drains the list in order.
module fault_collector #(
    parameter int ROW_W = bira_pkg::ROW_W,
    parameter int COL_W = bira_pkg::COL_W,
    parameter int DEPTH = bira_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             test,
    input  logic [1:0]       spare_struct,
    input  logic             flt_valid,
    input  logic [ROW_W-1:0] flt_row,
    input  logic [COL_W-1:0] flt_col,
    output logic             flt_ready,
    input  logic             test_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             out_last,
    output logic [3:0]       fault_cnt,
    output logic             early_term,
    output logic             test_end_for_time
);
    import bira_pkg::*;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             hold_q, hold_d;
    logic             tend_q, tend_d;
    logic             hit, wr_en, clr;
    logic             new_flt, overflow, drain_act;
    logic [ROW_W-1:0] rd_row;
    logic [COL_W-1:0] rd_col;

    fault_cam #(
        .ROW_W(ROW_W),
        .COL_W(COL_W),
        .DEPTH(DEPTH),
        .IDX_W(IDX_W)
    ) u_cam (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr),
        .wr_en_i  (wr_en),
        .wr_idx_i (IDX_W'(cnt_q)),
        .wr_row_i (flt_row),
        .wr_col_i (flt_col),
        .cmp_row_i(flt_row),
        .cmp_col_i(flt_col),
        .hit_o    (hit),
        .rd_idx_i (idx_q),
        .rd_row_o (rd_row),
        .rd_col_o (rd_col)
    );

    assign new_flt   = flt_valid && (state_q == COLLECT) && !hit;
    assign overflow  = new_flt && (cnt_q >= max_q);
    assign drain_act = (state_q == DRAIN) && (cnt_q != 4'd0);

    assign flt_ready         = (state_q == COLLECT);
    assign out_valid         = drain_act;
    assign out_last          = drain_act && ((4'(idx_q) + 4'd1) == cnt_q);
    assign fault_cnt         = cnt_q;
    assign early_term        = (state_q == TERM);
    assign test_end_for_time = tend_q;
    // After the final handshake the read index is parked on the last entry, so DONE keeps showing it.
    assign out_row = (drain_act || hold_q) ? rd_row : '0;
    assign out_col = (drain_act || hold_q) ? rd_col : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        tend_d  = 1'b0;
        wr_en   = 1'b0;
        clr     = 1'b0;
        if (!test) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            idx_d   = '0;
            hold_d  = 1'b0;
            clr     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = COLLECT;
                    max_d   = max_fault(spare_struct);
                end
                COLLECT: begin
                    if (overflow) begin
                        state_d = TERM;
                    end else begin
                        if (new_flt) begin
                            wr_en = 1'b1;
                            cnt_d = cnt_q + 4'd1;
                        end
                        if (test_done) begin
                            state_d = DRAIN;
                            tend_d  = 1'b1;
                            idx_d   = '0;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == 4'd0) begin
                        state_d = DONE;
                    end else if (out_ready) begin
                        if (out_last) begin
                            state_d = DONE;
                            hold_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE, TERM: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            max_q   <= 4'd0;
            idx_q   <= '0;
            hold_q  <= 1'b0;
            tend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            tend_q  <= tend_d;
        end
    end

endmodule

// File: tb/tb_fault_collector.sv
// Directed, table-driven bench for fault_collector: per-cycle input/expected-output
// records plus hand-written stall and asynchronous-reset sequences.
module tb_fault_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       test;
    logic [1:0] spare_struct;
    logic       flt_valid;
    logic [9:0] flt_row, flt_col;
    logic       flt_ready;
    logic       test_done;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_row, out_col;
    logic       out_last;
    logic [3:0] fault_cnt;
    logic       early_term;
    logic       test_end_for_time;

    always #5 clk = ~clk;

    fault_collector #(.ROW_W(10), .COL_W(10), .DEPTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .test             (test),
        .spare_struct     (spare_struct),
        .flt_valid        (flt_valid),
        .flt_row          (flt_row),
        .flt_col          (flt_col),
        .flt_ready        (flt_ready),
        .test_done        (test_done),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_row          (out_row),
        .out_col          (out_col),
        .out_last         (out_last),
        .fault_cnt        (fault_cnt),
        .early_term       (early_term),
        .test_end_for_time(test_end_for_time)
    );

    typedef struct {
        logic       tst;
        logic [1:0] sp;
        logic       fv;
        logic [9:0] fr;
        logic [9:0] fc;
        logic       td;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic [9:0] e_row;
        logic [9:0] e_col;
        logic       e_last;
        logic [3:0] e_cnt;
        logic       e_et;
        logic       e_te;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;

    function automatic vec_t mk(input int tst, input int sp, input int fv, input int fr,
                                input int fc, input int td, input int ordy,
                                input int rdy, input int ov, input int row, input int col,
                                input int last, input int cnt, input int et, input int te);
        vec_t v;
        v.tst = 1'(tst);  v.sp = 2'(sp);  v.fv = 1'(fv);  v.fr = 10'(fr);  v.fc = 10'(fc);
        v.td = 1'(td);    v.ordy = 1'(ordy);
        v.e_rdy = 1'(rdy); v.e_ov = 1'(ov); v.e_row = 10'(row); v.e_col = 10'(col);
        v.e_last = 1'(last); v.e_cnt = 4'(cnt); v.e_et = 1'(et); v.e_te = 1'(te);
        return v;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(negedge clk);
            test         = vecs[i].tst;
            spare_struct = vecs[i].sp;
            flt_valid    = vecs[i].fv;
            flt_row      = vecs[i].fr;
            flt_col      = vecs[i].fc;
            test_done    = vecs[i].td;
            out_ready    = vecs[i].ordy;
            @(posedge clk);
            #1;
            checks++;
            if ({flt_ready, out_valid, out_row, out_col, out_last, fault_cnt, early_term, test_end_for_time} !==
                {vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_row, vecs[i].e_col, vecs[i].e_last,
                 vecs[i].e_cnt, vecs[i].e_et, vecs[i].e_te}) begin
                errors++;
                $display("FAIL vec%0d actual rdy=%b ov=%b row=%0d col=%0d last=%b cnt=%0d et=%b te=%b required rdy=%b ov=%b row=%0d col=%0d last=%b cnt=%0d et=%b te=%b",
                         vec_no, flt_ready, out_valid, out_row, out_col, out_last, fault_cnt,
                         early_term, test_end_for_time, vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_row,
                         vecs[i].e_col, vecs[i].e_last, vecs[i].e_cnt, vecs[i].e_et, vecs[i].e_te);
            end
            vec_no++;
        end
        vecs.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_rdy"}, 32'(flt_ready), 32'd0);
        check1({tag, "_ov"}, 32'(out_valid), 32'd0);
        check1({tag, "_last"}, 32'(out_last), 32'd0);
        check1({tag, "_row"}, 32'(out_row), 32'd0);
        check1({tag, "_col"}, 32'(out_col), 32'd0);
        check1({tag, "_cnt"}, 32'(fault_cnt), 32'd0);
        check1({tag, "_et"}, 32'(early_term), 32'd0);
        check1({tag, "_te"}, 32'(test_end_for_time), 32'd0);
    endtask

    initial begin
        rst = 1'b0; test = 1'b0; spare_struct = 2'b00; flt_valid = 1'b0;
        flt_row = '0; flt_col = '0; test_done = 1'b0; out_ready = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Session A: spare 01, duplicate discarded, ordered drain, single end pulse.
        vecs.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 1,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,3,5,0,0, 1,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,1,1,7,2,0,0, 1,0,0,0,0,2,0,0));
        vecs.push_back(mk(1,1,1,3,5,0,0, 1,0,0,0,0,2,0,0));
        vecs.push_back(mk(1,1,0,0,0,1,0, 0,1,3,5,0,2,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,1, 0,1,7,2,1,2,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,1, 0,0,7,2,0,2,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 0,0,7,2,0,2,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        // Session B: spare 00 (limit 4), mid-session spare change ignored, TERM beats DRAIN.
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,1,0,0,0, 1,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,1,2,0,0,0, 1,0,0,0,0,2,0,0));
        vecs.push_back(mk(1,3,1,3,0,0,0, 1,0,0,0,0,3,0,0));
        vecs.push_back(mk(1,3,1,4,0,0,0, 1,0,0,0,0,4,0,0));
        vecs.push_back(mk(1,3,1,4,0,0,0, 1,0,0,0,0,4,0,0));
        vecs.push_back(mk(1,3,1,5,0,1,0, 0,0,0,0,0,4,1,0));
        vecs.push_back(mk(1,3,0,0,0,0,1, 0,0,0,0,0,4,1,0));
        vecs.push_back(mk(0,3,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        // Session C: no faults, straight to DONE.
        vecs.push_back(mk(1,3,0,0,0,0,0, 1,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,3,0,0,0,1,0, 0,0,0,0,0,0,0,1));
        vecs.push_back(mk(1,3,0,0,0,0,1, 0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,3,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        // Session D: fault and test_done in the same cycle.
        vecs.push_back(mk(1,2,0,0,0,0,0, 1,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,2,1,1,1,1,0, 0,1,1,1,1,1,0,1));
        vecs.push_back(mk(1,2,0,0,0,0,1, 0,0,1,1,0,1,0,0));
        vecs.push_back(mk(0,2,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        run_vecs();

        // Drain stalled by out_ready low for three cycles, then one transfer.
        vecs.push_back(mk(1,1,0,0,0,0,0, 1,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,9,8,0,0, 1,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,1,1,6,4,0,0, 1,0,0,0,0,2,0,0));
        vecs.push_back(mk(1,1,0,0,0,1,0, 0,1,9,8,0,2,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,0, 0,1,9,8,0,2,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 0,1,9,8,0,2,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 0,1,9,8,0,2,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,1, 0,1,6,4,1,2,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 0,1,6,4,1,2,0,0));
        run_vecs();

        // Asynchronous reset in the middle of DRAIN, away from any clock edge.
        @(negedge clk);
        #2;
        rst  = 1'b0;
        test = 1'b0;
        #1;
        check_all_zero("mid_drain_rst");
        @(negedge clk);
        rst = 1'b1;
        vecs.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 1,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,2,3,0,0, 1,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,1,1,9,8,1,0, 0,1,2,3,0,2,0,1));
        run_vecs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
